secded_scrubber: RTL
====================

Name: secded_scrubber

Overview:
- Background patrol scrubber for the SECDED-protected data memory.
- Walks every word in turn. For each word it reads the 39-bit codeword, computes the syndrome, and writes back the corrected codeword on a single-bit error. Double-bit errors are logged and never written.
- Sits beside the core-side data path and shares the memory port through a req/gnt arbiter in which the core has priority.
- Supplies the error counters and the last-error address to the lockstep/recovery logic.

Parameters:
- ADDR_W, 10, word-address width; scrub range is 0 .. 2^ADDR_W-1.
- INTERVAL, 256, idle cycles between consecutive word scrubs; must be at least 1.
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  in  1  clock
- rst_in  in  1  synchronous active-low reset
- enable  in  1  scrubbing permitted while 1
- mem_req  out  1  scrubber requests the memory port
- mem_gnt  in  1  arbiter grant; a transfer occurs in a cycle where mem_req and mem_gnt are both 1
- mem_we  out  1  1 = write transfer, 0 = read transfer
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  39  corrected codeword
- mem_rdata  in  39  read codeword, valid exactly 1 cycle after a granted read
- core_wr  in  1  core write to data memory this cycle
- core_wr_addr  in  ADDR_W  core write address
- sec_pulse  out  1  one-cycle pulse: single error corrected
- ded_pulse  out  1  one-cycle pulse: double error detected
- sec_count  out  CNT_W  saturating count of corrected errors
- ded_count  out  CNT_W  saturating count of detected uncorrectable errors
- last_err_addr  out  ADDR_W  address of the most recent SEC or DED event
- pass_done  out  1  one-cycle pulse when the address wraps from max to 0

Behaviour:
- Reset (rst_in==0 at a clk edge):
  - State goes to IDLE; address counter and interval counter go to 0.
  - All outputs are 0, including both counters and last_err_addr.
  - Reset mid-transfer drops mem_req on the same edge; no partial write is ever issued.
- Codeword layout:
  - bit 0 is overall parity over bits 38:1.
  - Bits 38:1 are Hamming positions 1..38; parity bits sit at positions 1, 2, 4, 8, 16 and 32, and data fills the remaining positions in ascending order.
- Syndrome classification (s = 6-bit Hamming syndrome, p = overall parity check, 1 = mismatch):
  - s==0, p==0: clean.
  - p==1: single error. If s==0, flip bit 0; otherwise flip position s. If s>38, classify as DED instead.
  - s!=0, p==0: DED.
- States:
  - IDLE: waits for enable==1, then goes to WAIT.
  - WAIT: interval counter counts to INTERVAL-1, then goes to RD.
  - RD: mem_req=1, mem_we=0, held until mem_gnt; then goes to RDW.
  - RDW: captures mem_rdata; goes to CHK.
  - CHK: classifies (1 cycle).
    - Clean: go to NXT.
    - SEC: load mem_wdata, go to WR.
    - DED: pulse ded_pulse, bump ded_count, update last_err_addr, go to NXT.
  - WR: mem_req=1, mem_we=1, held until mem_gnt. On the grant cycle, pulse sec_pulse, bump sec_count, update last_err_addr, then go to NXT.
  - NXT: address+1 with wrap to 0, and pass_done pulses on wrap. Go to WAIT if enable is 1, otherwise IDLE.
- Core collision: core_wr with core_wr_addr==current address in RDW, CHK or WR (including the grant cycle itself, since the core has priority) aborts the writeback.
  - No write, no counter change; go to NXT.
  - The core's fresh data is authoritative.
- enable falling mid-word: the current word completes through NXT, then the block goes to IDLE. enable has no effect on pulses in flight.
- Counters saturate at all-ones; pulses are still generated after saturation.
- mem_addr, mem_we and mem_wdata are stable while mem_req is 1 and not granted.

Optional Feature:
- SCRUB_VERIFY_EN defined:
  - After a granted WR, additional states VRD and VRDW re-read the same address.
  - If the re-read is not clean, assert ded_pulse and bump ded_count (location is stuck) before NXT.
  - A core collision during verify skips the check.
- Not defined: WR goes directly to NXT.

Decomposition:
- Package secded_pkg holds:
  - CODE_W=39, DATA_W=32, SYN_W=6.
  - State enum: IDLE, WAIT, RD, RDW, CHK, WR, NXT, VRD, VRDW.
  - Classification enum: CLEAN, SEC, DED.
- Sub-module secded_syndrome (combinational): codeword in; syndrome, overall-parity mismatch, classification and corrected codeword out. It is reused by the verify path.

Test Plan:
- Memory preloaded clean, enable=1, INTERVAL=4, mem_gnt tied 1 → no writes; sec_count=ded_count=0; pass_done pulses after 2^ADDR_W word cycles.
- Address 5 has data bit at position 3 flipped → one write to address 5 with the original codeword; sec_count=1, last_err_addr=5, sec_pulse 1 cycle.
- Address 7 has positions 3 and 9 flipped → no write; ded_count=1, last_err_addr=7; word left unchanged.
- SEC at address 9, mem_gnt held 0 for 10 cycles in WR → mem_req/mem_we/mem_addr/mem_wdata stable throughout; write happens on grant.
- SEC at address 12, core_wr to address 12 in CHK → no scrubber write; sec_count unchanged; next address 13.
- rst_in=0 during WR with mem_gnt=0 → next cycle mem_req=0, counters 0; no write observed.

Source files
------------

// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared widths, state/classification enums and the SECDED encoder
package secded_pkg;

    localparam int CODE_W = 39;
    localparam int DATA_W = 32;
    localparam int SYN_W  = 6;

    typedef enum logic [3:0] {
        IDLE,
        WAIT,
        RD,
        RDW,
        CHK,
        WR,
        NXT,
        VRD,
        VRDW
    } state_e;

    typedef enum logic [1:0] {
        CLEAN,
        SEC,
        DED
    } cls_e;

    // Builds a codeword: data in non-power-of-two Hamming positions 3..38 in
    // ascending order, parity at positions 1,2,4,..,32, overall parity in bit 0.
    function automatic logic [CODE_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] cw;
        logic [SYN_W-1:0]  s;
        int                j;
        cw = '0;
        s  = '0;
        j  = 0;
        for (int k = 1; k < CODE_W; k++) begin
            if ((k & (k - 1)) != 0) begin
                cw[k] = data[j];
                j++;
            end
        end
        for (int k = 1; k < CODE_W; k++) begin
            if (cw[k]) s ^= SYN_W'(k);
        end
        for (int b = 0; b < SYN_W; b++) begin
            cw[1 << b] = s[b];
        end
        cw[0] = ^cw[CODE_W-1:1];
        return cw;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// rtl/secded_syndrome.sv - combinational SECDED syndrome, classification and correction
// Ports:
//   codeword   in  39-bit codeword as read from memory
//   syndrome   out 6-bit Hamming syndrome (XOR of set positions 1..38)
//   parity_err out overall parity mismatch (1 = odd weight)
//   cls        out CLEAN / SEC / DED
//   corrected  out codeword with the indicated bit flipped (equals input unless SEC)
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CODE_W-1:0] codeword,
    output logic [SYN_W-1:0]  syndrome,
    output logic              parity_err,
    output cls_e              cls,
    output logic [CODE_W-1:0] corrected
);

    always_comb begin
        syndrome = '0;
        for (int k = 1; k < CODE_W; k++) begin
            if (codeword[k]) syndrome ^= SYN_W'(k);
        end
        parity_err = ^codeword;
        corrected  = codeword;
        cls        = CLEAN;
        if (parity_err) begin
            // syndrome 0 with a parity mismatch means bit 0 itself flipped, so
            // a single shift covers both the parity bit and positions 1..38.
            if (syndrome <= SYN_W'(CODE_W - 1)) begin
                cls       = SEC;
                corrected = codeword ^ (CODE_W'(1) << syndrome);
            end else begin
                cls = DED;
            end
        end else if (syndrome != '0) begin
            cls = DED;
        end
    end

endmodule

// File: rtl/secded_scrubber.sv
// rtl/secded_scrubber.sv - background patrol scrubber for SECDED-protected data memory
// Optional build macro: SCRUB_VERIFY_EN adds a re-read (VRD/VRDW) after each writeback.
// Ports:
//   clk, rst_in (sync active-low), enable
//   mem_req/mem_gnt/mem_we/mem_addr/mem_wdata/mem_rdata  shared memory port (rdata 1 cycle after read grant)
//   core_wr/core_wr_addr   core write snoop; a hit on the current word aborts its writeback
//   sec_pulse/ded_pulse    one-cycle event pulses
//   sec_count/ded_count    saturating event counters
//   last_err_addr          address of the latest SEC/DED event
//   pass_done              one-cycle pulse when the address wraps to 0
module secded_scrubber
    import secded_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int INTERVAL = 256,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              enable,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CODE_W-1:0] mem_wdata,
    input  logic [CODE_W-1:0] mem_rdata,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_wr_addr,
    output logic              sec_pulse,
    output logic              ded_pulse,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count,
    output logic [ADDR_W-1:0] last_err_addr,
    output logic              pass_done
);

    localparam int                IW        = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IW-1:0]     ICNT_LAST = IW'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e            state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [IW-1:0]     icnt;
    logic [CODE_W-1:0] rdata_q;
    logic [CODE_W-1:0] wdata_q;
    logic [CODE_W-1:0] syn_in;
    logic [CODE_W-1:0] corrected;
    logic [SYN_W-1:0]  syndrome;
    logic              parity_err;
    cls_e              cls;
    logic              collide;
    logic              capture;
    logic              load_wdata;
    logic              log_sec;
    logic              log_ded;
    logic              advance;
    logic              syn_unused;

    assign collide    = core_wr && (core_wr_addr == addr);
    assign mem_addr   = addr;
    assign mem_wdata  = wdata_q;
    assign syn_unused = ^{syndrome, parity_err};

`ifdef SCRUB_VERIFY_EN
    // The verify re-read is classified straight off the bus in VRDW.
    assign syn_in = (state == VRDW) ? mem_rdata : rdata_q;
`else
    assign syn_in = rdata_q;
`endif

    secded_syndrome u_syndrome (
        .codeword   (syn_in),
        .syndrome   (syndrome),
        .parity_err (parity_err),
        .cls        (cls),
        .corrected  (corrected)
    );

    always_comb begin
        state_n    = state;
        capture    = 1'b0;
        load_wdata = 1'b0;
        log_sec    = 1'b0;
        log_ded    = 1'b0;
        advance    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        unique case (state)
            IDLE: if (enable) state_n = WAIT;
            WAIT: begin
                if (!enable)                 state_n = IDLE;
                else if (icnt == ICNT_LAST)  state_n = RD;
            end
            RD: begin
                mem_req = 1'b1;
                if (mem_gnt) state_n = RDW;
            end
            RDW: begin
                capture = 1'b1;
                state_n = collide ? NXT : CHK;
            end
            CHK: begin
                if (collide || cls == CLEAN) begin
                    state_n = NXT;
                end else if (cls == SEC) begin
                    load_wdata = 1'b1;
                    state_n    = WR;
                end else begin
                    log_ded = 1'b1;
                    state_n = NXT;
                end
            end
            WR: begin
                // The core wins a same-address write even on the grant cycle,
                // so the request is withdrawn rather than letting stale data land.
                if (collide) begin
                    state_n = NXT;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    if (mem_gnt) begin
                        log_sec = 1'b1;
`ifdef SCRUB_VERIFY_EN
                        state_n = VRD;
`else
                        state_n = NXT;
`endif
                    end
                end
            end
            NXT: begin
                advance = 1'b1;
                state_n = enable ? WAIT : IDLE;
            end
`ifdef SCRUB_VERIFY_EN
            VRD: begin
                if (collide) begin
                    state_n = NXT;
                end else begin
                    mem_req = 1'b1;
                    if (mem_gnt) state_n = VRDW;
                end
            end
            VRDW: begin
                if (!collide && cls != CLEAN) log_ded = 1'b1;
                state_n = NXT;
            end
`endif
            default: state_n = IDLE;
        endcase
        // A reset cycle must never carry a transfer, even one already granted.
        if (!rst_in) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state         <= IDLE;
            addr          <= '0;
            icnt          <= '0;
            rdata_q       <= '0;
            wdata_q       <= '0;
            sec_pulse     <= 1'b0;
            ded_pulse     <= 1'b0;
            sec_count     <= '0;
            ded_count     <= '0;
            last_err_addr <= '0;
            pass_done     <= 1'b0;
        end else begin
            state     <= state_n;
            icnt      <= (state == WAIT && state_n == WAIT) ? icnt + 1'b1 : '0;
            sec_pulse <= log_sec;
            ded_pulse <= log_ded;
            pass_done <= advance && (addr == ADDR_LAST);
            if (capture)    rdata_q <= mem_rdata;
            if (load_wdata) wdata_q <= corrected;
            if (log_sec && sec_count != '1) sec_count <= sec_count + 1'b1;
            if (log_ded && ded_count != '1) ded_count <= ded_count + 1'b1;
            if (log_sec || log_ded) last_err_addr <= addr;
            if (advance) addr <= addr + 1'b1;
        end
    end

endmodule
